// File: rtl/lsh_pkg.sv
// rtl/lsh_pkg.sv - shared types and constants for the k-mer hashing / LSH path
package lsh_pkg;

    typedef logic [1:0] base_t;

    localparam logic [31:0] HASH_MULT = 32'h9E3779B1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/kmer_hash.sv
// rtl/kmer_hash.sv - combinational multiplicative hash of one packed k-mer
// h = top HASH_BITS of (kmer * HASH_MULT) mod 2^(2*KMER_SIZE)
module kmer_hash
    import lsh_pkg::*;
#(
    parameter int KMER_SIZE = 16,
    parameter int HASH_BITS = 16
) (
    input  logic [2*KMER_SIZE-1:0] kmer_i,
    output logic [HASH_BITS-1:0]   hash_o
);

    localparam int KW = 2 * KMER_SIZE;
    localparam logic [KW-1:0] MULT = KW'(HASH_MULT);

    // The product is taken modulo 2^KW by its self-determined width before the shift.
    assign hash_o = HASH_BITS'((kmer_i * MULT) >> (KW - HASH_BITS));

endmodule

// File: rtl/kmer_hash_engine.sv
// rtl/kmer_hash_engine.sv - walks every k-mer of a captured window, one hash per valid/ready beat
module kmer_hash_engine
    import lsh_pkg::*;
#(
    parameter int WINDOW_SIZE = 128,
    parameter int KMER_SIZE   = 16,
    parameter int HASH_BITS   = 16,
    parameter int WINDOW_ID_W = 1,
    localparam int NUM_KMERS  = WINDOW_SIZE - KMER_SIZE + 1,
    localparam int IDX_W      = (NUM_KMERS > 1) ? $clog2(NUM_KMERS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  base_t                  window_i [0:WINDOW_SIZE-1],
    input  logic [WINDOW_ID_W-1:0] window_id_i,
    input  logic                   is_insert_i,
    input  logic                   ready_for_hashing_i,
    input  logic                   window_reset_i,
    output logic                   window_ready_o,
    output logic                   hashing_is_done_o,
    output logic                   hash_valid_o,
    input  logic                   hash_ready_i,
    output logic [HASH_BITS-1:0]   hash_value_o,
    output logic [IDX_W-1:0]       hash_kmer_idx_o,
    output logic [WINDOW_ID_W-1:0] hash_window_id_o,
    output logic                   hash_is_insert_o
);

    localparam int KW = 2 * KMER_SIZE;
    localparam int WW = 2 * WINDOW_SIZE;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KMERS - 1);

    state_t                 state_q;
    logic [KW-1:0]          kmer_q;
    logic [WW-1:0]          tail_q;
    logic [IDX_W-1:0]       idx_q;
    logic [WINDOW_ID_W-1:0] id_q;
    logic                   ins_q;

    logic                   window_ready_q;
    logic                   done_q;
    logic                   valid_q;
    logic [HASH_BITS-1:0]   hash_q;
    logic [IDX_W-1:0]       out_idx_q;
    logic [WINDOW_ID_W-1:0] out_id_q;
    logic                   out_ins_q;

    logic [WW-1:0]          win_flat;
    logic [KW-1:0]          kmer_d;
    logic [HASH_BITS-1:0]   hash_d;
    logic                   issue;

    // window[0] lands in the MSBs so the first KW bits are k-mer 0.
    always_comb begin
        win_flat = '0;
        for (int j = 0; j < WINDOW_SIZE; j++) begin
            win_flat[WW-1-2*j -: 2] = window_i[j];
        end
    end

    // tail_q holds the not-yet-consumed bases, MSB-aligned; zeros once exhausted.
    assign kmer_d = (kmer_q << 2) | KW'(tail_q[WW-1 -: 2]);
    assign issue  = (state_q == RUN) && (!valid_q || hash_ready_i);

    kmer_hash #(
        .KMER_SIZE (KMER_SIZE),
        .HASH_BITS (HASH_BITS)
    ) u_kmer_hash (
        .kmer_i (kmer_q),
        .hash_o (hash_d)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            kmer_q         <= '0;
            tail_q         <= '0;
            idx_q          <= '0;
            id_q           <= '0;
            ins_q          <= 1'b0;
            window_ready_q <= 1'b0;
            done_q         <= 1'b0;
            valid_q        <= 1'b0;
            hash_q         <= '0;
            out_idx_q      <= '0;
            out_id_q       <= '0;
            out_ins_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (window_reset_i) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        window_ready_q <= 1'b1;
                        if (ready_for_hashing_i && window_ready_q) begin
                            kmer_q         <= win_flat[WW-1 -: KW];
                            tail_q         <= win_flat << KW;
                            idx_q          <= '0;
                            id_q           <= window_id_i;
                            ins_q          <= is_insert_i;
                            window_ready_q <= 1'b0;
                            state_q        <= RUN;
                        end
                    end
                    RUN: begin
                        if (issue) begin
                            hash_q    <= hash_d;
                            out_idx_q <= idx_q;
                            out_id_q  <= id_q;
                            out_ins_q <= ins_q;
                            valid_q   <= 1'b1;
                            kmer_q    <= kmer_d;
                            tail_q    <= tail_q << 2;
                            idx_q     <= idx_q + IDX_W'(1);
                            if (idx_q == LAST_IDX) begin
                                state_q <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (valid_q && hash_ready_i) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign window_ready_o    = window_ready_q;
    assign hashing_is_done_o = done_q;
    assign hash_valid_o      = valid_q;
    assign hash_value_o      = hash_q;
    assign hash_kmer_idx_o   = out_idx_q;
    assign hash_window_id_o  = out_id_q;
    assign hash_is_insert_o  = out_ins_q;

endmodule

// File: tb/tb_kmer_hash_engine.sv
// tb/tb_kmer_hash_engine.sv - scoreboard bench for kmer_hash_engine
module tb_kmer_hash_engine;

    localparam int WS = 128;
    localparam int NK = 113;

    typedef struct packed {
        logic [15:0] v;
        logic [6:0]  idx;
        logic        id;
        logic        ins;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  win [0:WS-1];
    logic        wid = 1'b0;
    logic        ins = 1'b0;
    logic        rfh = 1'b0;
    logic        wrst = 1'b0;
    logic        hready = 1'b1;
    logic        wready, done, hvalid, hwid, hins;
    logic [15:0] hval;
    logic [6:0]  hidx;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   last_acc = -10;
    int   rmode = 0;

    kmer_hash_engine dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .window_i            (win),
        .window_id_i         (wid),
        .is_insert_i         (ins),
        .ready_for_hashing_i (rfh),
        .window_reset_i      (wrst),
        .window_ready_o      (wready),
        .hashing_is_done_o   (done),
        .hash_valid_o        (hvalid),
        .hash_ready_i        (hready),
        .hash_value_o        (hval),
        .hash_kmer_idx_o     (hidx),
        .hash_window_id_o    (hwid),
        .hash_is_insert_o    (hins)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [1:0] b);
        for (int i = 0; i < WS; i++) win[i] = b;
    endtask

    // Downstream ready: always 1, or a pseudo-random pattern in stall mode.
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        hready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops on every accepted beat, checks stalls and the done pulse.
    initial begin
        exp_t cur, held, e;
        logic stall_prev;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            cur = {hval, hidx, hwid, hins};
            if (stall_prev) chk("stall_hold", {1'b0, hvalid, cur}, {1'b0, 1'b1, held});
            if (hvalid && hready) begin
                if (q.size() == 0) begin
                    chk("unexpected_hash", {hidx, hval}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("hash_entry", cur, e);
                    if (rmode == 0 && e.idx != 0) chk("back_to_back", cyc, last_acc + 1);
                    last_acc = cyc;
                end
            end
            stall_prev = hvalid && !hready;
            held = cur;
            if (done) begin
                done_cnt++;
                chk("done_latency", cyc, last_acc + 1);
                chk("done_queue_empty", q.size(), 0);
            end
        end
    end

    task automatic start(input logic id, input logic in_, input logic [15:0] e0, input logic [15:0] er);
        int   n;
        exp_t e;
        n = 0;
        while (!wready && n < 50) begin
            tick();
            n++;
        end
        chk("window_ready_before_start", wready, 1);
        for (int i = 0; i < NK; i++) begin
            e.v = (i == 0) ? e0 : er;
            e.idx = 7'(i);
            e.id = id;
            e.ins = in_;
            q.push_back(e);
        end
        wid = id;
        ins = in_;
        rfh = 1'b1;
        tick();
        rfh = 1'b0;
        fill(2'b10);
        chk("valid_low_after_T", hvalid, 0);
        chk("ready_low_in_run", wready, 0);
        tick();
        chk("valid_after_T1", hvalid, 1);
        chk("first_idx", hidx, 0);
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 2000) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk("done_count", done_cnt, target);
    endtask

    task automatic wait_idx(input logic [6:0] target, output bit found);
        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clk);
            if (hvalid && hidx == target) found = 1'b1;
        end
    endtask

    initial begin
        bit found;
        fill(2'b00);
        repeat (3) tick();
        chk("reset_outputs", {wready, done, hvalid, hval, hidx, hwid, hins}, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_reset", wready, 1);

        fill(2'b00);
        start(1'b0, 1'b0, 16'h0000, 16'h0000);
        wait_done(1);

        fill(2'b11);
        start(1'b0, 1'b0, 16'h61C8, 16'h61C8);
        wait_done(2);

        fill(2'b00);
        win[0] = 2'b01;
        start(1'b0, 1'b0, 16'h4000, 16'h0000);
        wait_done(3);

        rmode = 1;
        fill(2'b11);
        start(1'b1, 1'b0, 16'h61C8, 16'h61C8);
        wait_done(4);
        rmode = 0;
        tick();

        // Abort at idx 50, then a tagged window must run to completion.
        fill(2'b11);
        start(1'b0, 1'b0, 16'h61C8, 16'h61C8);
        wait_idx(7'd50, found);
        chk("reached_idx50", found, 1);
        wrst = 1'b1;
        @(posedge clk);
        #1;
        wrst = 1'b0;
        @(negedge clk);
        chk("valid_cleared_by_window_reset", hvalid, 0);
        q.delete();
        tick();
        chk("ready_after_window_reset", wready, 1);
        chk("no_done_on_abort", done_cnt, 4);
        fill(2'b00);
        start(1'b1, 1'b1, 16'h0000, 16'h0000);
        wait_done(5);

        wrst = 1'b1;
        rfh = 1'b1;
        tick();
        wrst = 1'b0;
        rfh = 1'b0;
        repeat (2) tick();
        chk("no_capture_under_window_reset", hvalid, 0);
        chk("still_idle_after_blocked_handshake", wready, 1);

        fill(2'b11);
        start(1'b1, 1'b1, 16'h61C8, 16'h61C8);
        wait_idx(7'd10, found);
        chk("reached_idx10", found, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("outputs_cleared_by_rst", {wready, done, hvalid, hval, hidx, hwid, hins}, 0);
        rst = 1'b0;
        q.delete();
        tick();
        chk("ready_after_mid_rst", wready, 1);
        chk("no_done_on_rst", done_cnt, 5);

        repeat (3) tick();
        chk("queue_empty_end", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL timeout: got running expected finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
